// File: rtl/datapath_sequencer.sv
// Issue/read/execute/write-back sequencer sitting upstream of an 8x16 register file.
// Single-cycle ALU operations plus an iterative unsigned shift-add multiply.
//
// state | meaning
// IDLE  | ready, waits for instr_valid and latches the instruction
// READ  | register file addressed with src_a/src_b, operands latched at the edge
// EXEC  | result and flags registered (MUL iterates MUL_CYCLES edges here)
// WRITE | write port driven for one cycle, register file captures at the edge
module datapath_sequencer #(
  parameter int WIDTH      = 16,
  parameter int AW         = 3,
  parameter int MUL_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       opcode,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  input  logic [AW-1:0]    dst,
  input  logic [WIDTH-1:0] imm,
  output logic [AW-1:0]    AAddress,
  output logic [AW-1:0]    BAddress,
  input  logic [WIDTH-1:0] AData,
  input  logic [WIDTH-1:0] BData,
  output logic [AW-1:0]    DAddress,
  output logic [WIDTH-1:0] DData,
  output logic             ReadOrWrite,
  output logic             busy,
  output logic             done,
  output logic             flag_z,
  output logic             flag_c
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_LDI, OP_MUL
  } op_t;

  state_t             state, state_next;
  op_t                op_q;
  logic [AW-1:0]      src_a_q, src_b_q, dst_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   opa, opb;
  logic [WIDTH-1:0]   result_q;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] shl_full;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               mul_last;

  // single-cycle ALU; widened intermediates expose carry, borrow and shifted-out bit
  always_comb begin
    sum      = {1'b0, opa} + {1'b0, opb};
    diff     = {1'b0, opa} - {1'b0, opb};
    shl_full = {{WIDTH{1'b0}}, opa} << opb[SW-1:0];
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
      end
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      OP_XOR: alu_res = opa ^ opb;
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      OP_LDI: alu_res = imm_q;
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
      end
    endcase
  end

  assign acc_next = acc + (mplr[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(MUL_CYCLES - 1));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (instr_valid) state_next = S_READ;
      S_READ:  state_next = S_EXEC;
      S_EXEC:  if (op_q != OP_MUL || mul_last) state_next = S_WRITE;
      S_WRITE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_ADD;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      opa      <= '0;
      opb      <= '0;
      result_q <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      acc      <= '0;
      mcand    <= '0;
      mplr     <= '0;
      cnt      <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q    <= op_t'(opcode);
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            imm_q   <= imm;
          end
        end
        S_READ: begin
          opa   <= AData;
          opb   <= BData;
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, AData};
          mplr  <= BData;
          cnt   <= '0;
        end
        S_EXEC: begin
          if (op_q == OP_MUL) begin
            // one multiplier bit per edge; the final partial sum is the product
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
            if (mul_last) begin
              result_q <= acc_next[WIDTH-1:0];
              flag_z   <= (acc_next[WIDTH-1:0] == '0);
              flag_c   <= |acc_next[2*WIDTH-1:WIDTH];
            end
          end else begin
            result_q <= alu_res;
            flag_z   <= (alu_res == '0);
            flag_c   <= alu_c;
          end
        end
        default: ;
      endcase
    end
  end

  // a reset arriving in the WRITE cycle must stop the register file capture at that edge
  assign ReadOrWrite = (state == S_WRITE) && !rst;
  assign done        = ReadOrWrite;
  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign AAddress    = src_a_q;
  assign BAddress    = src_b_q;
  assign DAddress    = dst_q;
  assign DData       = result_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: register file model, directed plan plus random
// instructions, checked every cycle against an instruction-level reference model.
module tb_datapath_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  opcode = '0;
  logic [2:0]  src_a = '0, src_b = '0, dst = '0;
  logic [15:0] imm = '0;
  logic [2:0]  AAddress, BAddress, DAddress;
  logic [15:0] AData, BData, DData;
  logic        ReadOrWrite, busy, done, flag_z, flag_c;

  always #5 clk = ~clk;

  datapath_sequencer #(.WIDTH(16), .AW(3), .MUL_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
    .AAddress(AAddress), .BAddress(BAddress), .AData(AData), .BData(BData),
    .DAddress(DAddress), .DData(DData), .ReadOrWrite(ReadOrWrite),
    .busy(busy), .done(done), .flag_z(flag_z), .flag_c(flag_c)
  );

  // register file the DUT drives
  logic [15:0] rf [8] = '{default: 16'h0};
  assign AData = rf[AAddress];
  assign BData = rf[BAddress];
  always @(posedge clk) if (ReadOrWrite) rf[DAddress] <= DData;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] im, output logic [15:0] r,
                                   output bit z, output bit c);
    logic [31:0] w;
    int n;
    c = 1'b0;
    r = '0;
    case (op)
      3'd0: begin w = 32'(a) + 32'(b); r = w[15:0]; c = w[16]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        n = int'(b[3:0]);
        r = a << n;
        c = (n != 0) && (((a >> (16 - n)) & 16'h1) != 16'h0);
      end
      3'd6: r = im;
      default: begin w = 32'(a) * 32'(b); r = w[15:0]; c = (w[31:16] != 16'h0); end
    endcase
    z = (r == 16'h0);
  endfunction

  // reference model: one pending instruction, write edge fixed by latency
  int          cyc = 0;
  bit          pending = 0;
  int          wr_edge = 0;
  int          acc_cnt = 0, acc_cyc = 0;
  logic [15:0] m_rf [8] = '{default: 16'h0};
  logic [2:0]  p_dst, p_a, p_b;
  logic [15:0] p_res;
  bit          p_z, p_c;
  bit          e_ready = 1, e_busy = 0, e_we = 0, e_z = 0, e_c = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pending = 0;
      e_ready = 1; e_busy = 0; e_we = 0; e_z = 0; e_c = 0;
    end else begin
      if (pending && cyc == wr_edge) begin
        m_rf[p_dst] = p_res;
        pending = 0;
      end else if (!pending && instr_valid) begin
        model_op(opcode, m_rf[src_a], m_rf[src_b], imm, p_res, p_z, p_c);
        p_dst = dst; p_a = src_a; p_b = src_b;
        wr_edge = cyc + ((opcode == 3'b111) ? 18 : 3);
        pending = 1;
        acc_cnt++;
        acc_cyc = cyc;
      end
      e_busy  = pending;
      e_ready = !pending;
      e_we    = pending && (cyc == wr_edge - 1);
      if (e_we) begin e_z = p_z; e_c = p_c; end
    end
  end

  int          wr_cnt = 0, last_wr_edge = 0;
  logic [15:0] last_d;
  bit          last_z, last_c, exp_we;

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_we = e_we && !rst;
      chk("instr_ready", instr_ready, e_ready);
      chk("busy", busy, e_busy);
      chk("ReadOrWrite", ReadOrWrite, exp_we);
      chk("done", done, exp_we);
      chk("flag_z", flag_z, e_z);
      chk("flag_c", flag_c, e_c);
      if (exp_we) begin
        chk("DAddress", DAddress, p_dst);
        chk("DData", DData, p_res);
      end
      if (e_busy) begin
        chk("AAddress", AAddress, p_a);
        chk("BAddress", BAddress, p_b);
      end
      if (ReadOrWrite) begin
        wr_cnt++;
        last_wr_edge = cyc + 1;
        last_d = DData; last_z = flag_z; last_c = flag_c;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic [15:0] im, input bit junk);
    int a0 = acc_cnt;
    bit got = 0;
    instr_valid = 1; opcode = op; src_a = a; src_b = b; dst = d; imm = im;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != a0) got = 1;
    end
    if (!got) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
    end
    if (junk) begin
      for (int j = 0; j < 2; j++) begin
        opcode = 3'($urandom); src_a = 3'($urandom); src_b = 3'($urandom);
        dst = 3'($urandom); imm = 16'($urandom);
        @(posedge clk); #2;
      end
    end
    instr_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pending; i++) begin
      @(posedge clk); #2;
    end
    if (pending) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got pending write, expected completion within 40 cycles");
    end
  endtask

  task automatic reset_checks();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", ReadOrWrite, 0);
    chk("rst_flag_z", flag_z, 0);
    chk("rst_flag_c", flag_c, 0);
    chk("rst_DData", DData, 0);
    chk("rst_DAddress", DAddress, 0);
    chk("rst_AAddress", AAddress, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    int w0, d0;
    repeat (2) @(posedge clk);
    #2;
    reset_checks();
    rst = 0;

    d0 = wr_cnt;
    issue(3'd6, 0, 0, 1, 16'h1234, 0);
    issue(3'd6, 0, 0, 2, 16'h00FF, 0);
    issue(3'd0, 1, 2, 3, 16'h0, 0);
    drain();
    chk("add_r3", rf[3], 16'h1333);
    chk("add_z", last_z, 0);
    chk("add_c", last_c, 0);
    chk("add_latency", last_wr_edge - acc_cyc, 3);
    chk("three_writes", wr_cnt - d0, 3);

    issue(3'd1, 2, 1, 4, 16'h0, 0); drain();
    chk("sub_r4", rf[4], 16'hEECB);
    chk("sub_borrow", last_c, 1);
    issue(3'd1, 1, 1, 5, 16'h0, 0); drain();
    chk("sub_self", rf[5], 16'h0000);
    chk("sub_self_z", last_z, 1);
    chk("sub_self_c", last_c, 0);

    issue(3'd6, 0, 0, 6, 16'hFFFF, 0);
    issue(3'd6, 0, 0, 7, 16'h0001, 0);
    issue(3'd0, 6, 7, 0, 16'h0, 0); drain();
    chk("add_wrap", rf[0], 16'h0000);
    chk("add_wrap_z", last_z, 1);
    chk("add_wrap_c", last_c, 1);

    issue(3'd6, 0, 0, 6, 16'h8001, 0);
    issue(3'd5, 6, 7, 0, 16'h0, 0); drain();
    chk("shl1", rf[0], 16'h0002);
    chk("shl1_c", last_c, 1);
    issue(3'd6, 0, 0, 7, 16'h0000, 0);
    issue(3'd5, 6, 7, 0, 16'h0, 0); drain();
    chk("shl0", rf[0], 16'h8001);
    chk("shl0_c", last_c, 0);

    issue(3'd6, 0, 0, 6, 16'h0100, 0);
    issue(3'd7, 6, 6, 0, 16'h0, 0); drain();
    chk("mul_ovf", rf[0], 16'h0000);
    chk("mul_ovf_c", last_c, 1);
    chk("mul_ovf_z", last_z, 1);
    chk("mul_latency", last_wr_edge - acc_cyc, 18);
    issue(3'd6, 0, 0, 6, 16'h00FF, 0);
    issue(3'd6, 0, 0, 7, 16'h0003, 0);
    issue(3'd7, 6, 7, 0, 16'h0, 0); drain();
    chk("mul_small", rf[0], 16'h02FD);
    chk("mul_small_c", last_c, 0);

    d0 = wr_cnt;
    issue(3'd4, 6, 7, 5, 16'h0, 1); drain();
    chk("junk_one_write", wr_cnt - d0, 1);
    chk("xor_r5", rf[5], 16'h00FC);
    issue(3'd6, 0, 0, 1, 16'h0003, 0);
    issue(3'd0, 1, 1, 1, 16'h0, 0);
    issue(3'd0, 1, 1, 1, 16'h0, 0); drain();
    chk("dep_chain", rf[1], 16'h000C);

    // reset inside MUL execution
    issue(3'd6, 0, 0, 2, 16'h0005, 0);
    issue(3'd1, 1, 1, 0, 16'h0, 0); drain();
    w0 = wr_cnt;
    issue(3'd7, 6, 7, 2, 16'h0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #2;
    rst = 0;
    reset_checks();
    repeat (25) @(posedge clk);
    #2;
    chk("mul_rst_no_write", wr_cnt - w0, 0);
    chk("mul_rst_r2", rf[2], 16'h0005);

    // reset during the WRITE cycle
    issue(3'd1, 1, 1, 0, 16'h0, 0); drain();
    w0 = wr_cnt;
    issue(3'd0, 1, 1, 2, 16'h0, 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("wr_rst_suppress", ReadOrWrite, 0);
    chk("wr_rst_done", done, 0);
    @(posedge clk); #2;
    rst = 0;
    reset_checks();
    chk("wr_rst_no_write", wr_cnt - w0, 0);
    chk("wr_rst_r2", rf[2], 16'h0005);

    for (int k = 0; k < 80; k++) begin
      issue(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
    end
    drain();
    for (int r = 0; r < 8; r++) chk($sformatf("rf_final_r%0d", r), rf[r], m_rf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
